// File: rtl/mul_div_unit.sv
// Iterative multiply/divide unit with HI/LO result registers.
// Shift-add multiply and restoring divide, one bit per clock, followed by a
// single sign-fixup cycle that writes HI/LO and pulses Done.
module mul_div_unit #(
  parameter int Data_Width = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Start,
  input  logic [1:0]            Op,
  input  logic [Data_Width-1:0] A,
  input  logic [Data_Width-1:0] B,
  input  logic                  HI_Write,
  input  logic                  LO_Write,
  input  logic [Data_Width-1:0] Write_Data,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Div_By_Zero,
  output logic [Data_Width-1:0] HI,
  output logic [Data_Width-1:0] LO
);

  localparam int W  = Data_Width;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

  // Conditional two's-complement negate, single and double width.
  function automatic logic [W-1:0] cneg_w(input logic [W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*W-1:0] cneg_2w(input logic [2*W-1:0] v, input logic neg);
    return neg ? (~v + 1'b1) : v;
  endfunction

  // Control state
  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            is_div_q, is_div_d;
  logic            neg_res_q, neg_res_d;   // product / quotient sign
  logic            neg_rem_q, neg_rem_d;   // remainder sign follows dividend
  logic            dz_q, dz_d;
  logic            done_q, done_d;
  logic            dbz_q, dbz_d;
  logic [W-1:0]    hi_q, hi_d;
  logic [W-1:0]    lo_q, lo_d;

  // Datapath state: {upper, lower} = {partial product, multiplier} or {remainder, quotient}
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    dvs_q, dvs_d;           // multiplicand / divisor magnitude
  logic [W-1:0]    dvd_q, dvd_d;           // raw dividend, returned in HI on divide-by-zero

  logic            accept;
  logic            sgn_a, sgn_b;
  logic [W-1:0]    mag_a, mag_b;
  logic [W:0]      mul_sum;
  logic [W:0]      div_sh;
  logic [W:0]      div_diff;
  logic            div_ok;
  logic [2*W-1:0]  prod_fix;
  logic [W-1:0]    quo_fix, rem_fix;

  assign accept   = (state_q == S_IDLE) && Start;
  assign sgn_a    = Op[0] & A[W-1];
  assign sgn_b    = Op[0] & B[W-1];
  assign mag_a    = cneg_w(A, sgn_a);
  assign mag_b    = cneg_w(B, sgn_b);

  assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, dvs_q} : {(W+1){1'b0}});
  assign div_sh   = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff = div_sh - {1'b0, dvs_q};
  assign div_ok   = ~div_diff[W];

  assign prod_fix = cneg_2w(acc_q, neg_res_q);
  assign quo_fix  = cneg_w(acc_q[W-1:0], neg_res_q);
  assign rem_fix  = cneg_w(acc_q[2*W-1:W], neg_rem_q);

  // Next-state and HI/LO update logic for the controller
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dbz_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          state_d   = Op[1] ? S_DIV : S_MUL;
          cnt_d     = CW'(W);
          is_div_d  = Op[1];
          neg_res_d = sgn_a ^ sgn_b;
          neg_rem_d = sgn_a;
          dz_d      = Op[1] && (B == '0);
        end else begin
          if (HI_Write) hi_d = Write_Data;
          if (LO_Write) lo_d = Write_Data;
        end
      end
      S_MUL, S_DIV: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        dbz_d   = dz_q;
        if (!is_div_q) begin
          hi_d = prod_fix[2*W-1:W];
          lo_d = prod_fix[W-1:0];
        end else if (dz_q) begin
          hi_d = dvd_q;
          lo_d = '1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Iteration datapath: load magnitudes on accept, then one bit per cycle
  always_comb begin
    acc_d = acc_q;
    dvs_d = dvs_q;
    dvd_d = dvd_q;
    if (accept) begin
      acc_d = {{W{1'b0}}, mag_a};
      dvs_d = mag_b;
      dvd_d = A;
    end else if (state_q == S_MUL) begin
      acc_d = {mul_sum, acc_q[W-1:1]};
    end else if (state_q == S_DIV) begin
      acc_d = div_ok ? {div_diff[W-1:0], acc_q[W-2:0], 1'b1}
                     : {div_sh[W-1:0],   acc_q[W-2:0], 1'b0};
    end
  end

  // Control and result registers, cleared by reset at any time
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      done_q    <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      done_q    <= done_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Working registers; contents are only meaningful while an op is in flight
  always_ff @(posedge CLK) begin
    acc_q <= acc_d;
    dvs_q <= dvs_d;
    dvd_q <= dvd_d;
  end

  assign Busy        = (state_q != S_IDLE);
  assign Done        = done_q;
  assign Div_By_Zero = dbz_q;
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Testbench for mul_div_unit: directed cases plus randomized ops against an
// arithmetic reference model.
module tb_mul_div_unit;

  localparam int W = 32;

  logic         CLK;
  logic         RST;
  logic         Start;
  logic [1:0]   Op;
  logic [W-1:0] A, B;
  logic         HI_Write, LO_Write;
  logic [W-1:0] Write_Data;
  logic         Busy, Done, Div_By_Zero;
  logic [W-1:0] HI, LO;

  int n_cmp = 0;
  int n_err = 0;

  mul_div_unit #(.Data_Width(W)) dut (
    .CLK(CLK), .RST(RST), .Start(Start), .Op(Op), .A(A), .B(B),
    .HI_Write(HI_Write), .LO_Write(LO_Write), .Write_Data(Write_Data),
    .Busy(Busy), .Done(Done), .Div_By_Zero(Div_By_Zero), .HI(HI), .LO(LO)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural operands
  function automatic void model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo, output logic dz);
    longint sa, sb, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin r = sa * sb; p = r; hi = p[63:32]; lo = p[31:0]; end
      2'b10: begin
        if (b == 0) begin dz = 1'b1; hi = a; lo = '1; end
        else begin hi = a % b; lo = a / b; end
      end
      default: begin
        if (b == 0) begin dz = 1'b1; hi = a; lo = '1; end
        else begin
          r = sa / sb; p = r; lo = p[31:0];
          r = sa % sb; p = r; hi = p[31:0];
        end
      end
    endcase
  endfunction

  // Launch one op at the current (post-edge) time and check it through its Done cycle.
  // Returns with the bench sitting in the Done cycle so the caller can chain a Start.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit poke, input bit idle_write, input string tag);
    logic [W-1:0] ehi, elo;
    logic         edz;
    int           busy_n;
    bit           seen;
    model(op, a, b, ehi, elo, edz);
    Start = 1'b1; Op = op; A = a; B = b;
    HI_Write = idle_write; LO_Write = idle_write; Write_Data = 32'h5A5A_0F0F;
    step();
    Start = 1'b0; HI_Write = 1'b0; LO_Write = 1'b0;
    A = $urandom; B = $urandom; Op = 2'($urandom_range(0, 3));
    busy_n = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Done) begin seen = 1'b1; break; end
      if (Busy) busy_n++;
      if (poke && i == 5) begin
        Start = 1'b1; HI_Write = 1'b1; LO_Write = 1'b1; Write_Data = $urandom;
      end else begin
        Start = 1'b0; HI_Write = 1'b0; LO_Write = 1'b0;
      end
      step();
    end
    Start = 1'b0; HI_Write = 1'b0; LO_Write = 1'b0;
    check({tag, " done"}, 64'(seen), 64'(1));
    check({tag, " busy_cycles"}, 64'(busy_n), 64'(W + 1));
    check({tag, " busy_in_done"}, 64'(Busy), 64'(0));
    check({tag, " HI"}, 64'(HI), 64'(ehi));
    check({tag, " LO"}, 64'(LO), 64'(elo));
    check({tag, " dbz"}, 64'(Div_By_Zero), 64'(edz));
  endtask

  initial begin
    logic [1:0]   rop;
    logic [W-1:0] ra, rb;
    int           done_n;

    RST = 1'b0; Start = 1'b0; Op = 2'b00; A = '0; B = '0;
    HI_Write = 1'b0; LO_Write = 1'b0; Write_Data = '0;
    step();
    step();
    check("reset HI", 64'(HI), 64'(0));
    check("reset LO", 64'(LO), 64'(0));
    check("reset busy", 64'(Busy), 64'(0));
    check("reset done", 64'(Done), 64'(0));
    check("reset dbz", 64'(Div_By_Zero), 64'(0));
    RST = 1'b1;
    step();

    // Directed arithmetic cases
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, "multu_max");
    step();
    check("done_pulse_width", 64'(Done), 64'(0));
    run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0, 1'b0, "mult_neg3x7");
    check("mult_neg3x7 HI const", 64'(HI), 64'(32'hFFFF_FFFF));
    check("mult_neg3x7 LO const", 64'(LO), 64'(32'hFFFF_FFEB));
    step();
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, "div_neg7by2");
    check("div_neg7by2 LO const", 64'(LO), 64'(32'hFFFF_FFFD));
    step();
    run_op(2'b10, 32'd100, 32'd7, 1'b0, 1'b0, "divu_100by7");
    check("divu_100by7 LO const", 64'(LO), 64'(14));
    check("divu_100by7 HI const", 64'(HI), 64'(2));
    step();
    run_op(2'b10, 32'h0000_1234, 32'd0, 1'b0, 1'b0, "divu_by0");
    check("divu_by0 HI const", 64'(HI), 64'(32'h1234));
    step();
    check("dbz_clears", 64'(Div_By_Zero), 64'(0));
    run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, "div_overflow");
    check("div_overflow LO const", 64'(LO), 64'(32'h8000_0000));
    step();
    run_op(2'b11, 32'hFFFF_FF00, 32'd0, 1'b0, 1'b0, "div_signed_by0");
    step();

    // Start/HI_Write/LO_Write mid-op ignored; Start beats a same-cycle idle write
    run_op(2'b01, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, "mult_poke");
    // Back-to-back: Start issued in the Done cycle
    run_op(2'b10, 32'hDEAD_BEEF, 32'h0000_0013, 1'b0, 1'b1, "divu_b2b_wr");
    run_op(2'b11, 32'h1234_5678, 32'hFFFF_FF85, 1'b0, 1'b0, "div_b2b");
    step();

    // Randomized ops with a mix of divisor shapes
    for (int n = 0; n < 24; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = 32'($urandom_range(1, 20));
        2:       rb = 32'hFFFF_FFFF;
        3:       rb = 32'h8000_0000;
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      run_op(rop, ra, rb, bit'($urandom_range(0, 1)), 1'b0, "rand");
      if ($urandom_range(0, 1) == 1) step();
    end
    step();

    // Reset in the middle of a divide
    Start = 1'b1; Op = 2'b11; A = 32'hFFFF_0001; B = 32'd3;
    step();
    Start = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("pre_reset busy", 64'(Busy), 64'(1));
    RST = 1'b0;
    #1;
    check("midop_reset HI", 64'(HI), 64'(0));
    check("midop_reset LO", 64'(LO), 64'(0));
    check("midop_reset busy", 64'(Busy), 64'(0));
    check("midop_reset done", 64'(Done), 64'(0));
    step();
    RST = 1'b1;
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) done_n++;
      step();
    end
    check("post_reset no_done", 64'(done_n), 64'(0));
    check("post_reset busy", 64'(Busy), 64'(0));

    // MTLO / MTHI while idle
    LO_Write = 1'b1; Write_Data = 32'hA5A5_A5A5;
    #1;
    check("mtlo before_edge", 64'(LO), 64'(0));
    step();
    LO_Write = 1'b0;
    check("mtlo LO", 64'(LO), 64'(32'hA5A5_A5A5));
    check("mtlo HI untouched", 64'(HI), 64'(0));
    HI_Write = 1'b1; LO_Write = 1'b1; Write_Data = 32'h0BAD_F00D;
    step();
    HI_Write = 1'b0; LO_Write = 1'b0; Write_Data = 32'h1111_2222;
    check("mthi_mtlo HI", 64'(HI), 64'(32'h0BAD_F00D));
    check("mthi_mtlo LO", 64'(LO), 64'(32'h0BAD_F00D));
    step();
    step();
    check("hold HI", 64'(HI), 64'(32'h0BAD_F00D));
    check("hold LO", 64'(LO), 64'(32'h0BAD_F00D));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
